// File: rtl/mm_pkg.sv
// Shared Mastermind definitions: code geometry, scorer state encoding and peg/count helpers.
package mm_pkg;

  localparam int PEGS    = 4;
  localparam int COLOR_W = 3;
  localparam int COLORS  = 1 << COLOR_W;
  localparam int CODE_W  = PEGS * COLOR_W;
  localparam int CNT_W   = 3;

  localparam logic [CNT_W-1:0]   PEGS_CNT   = 3'd4;
  localparam logic [COLOR_W-1:0] LAST_PEG   = 3'd3;
  localparam logic [COLOR_W-1:0] LAST_COLOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEG   = 2'd1,
    COLOR = 2'd2
  } state_e;

  // Peg i lives at bits [COLOR_W*i +: COLOR_W]; the history store uses the same packing.
  function automatic logic [COLOR_W-1:0] peg_slice(input logic [CODE_W-1:0] code,
                                                   input logic [1:0]        idx);
    peg_slice = code[COLOR_W*idx +: COLOR_W];
  endfunction

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    if (a < b) begin
      min_cnt = a;
    end else begin
      min_cnt = b;
    end
  endfunction

endpackage

// File: rtl/guess_scorer.sv
// Iterative Mastermind scorer: exact hits one peg per cycle, then partial hits one colour per cycle.
// Owns the sticky game-over flags win and lose.
module guess_scorer
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] guess,
  input  logic [CODE_W-1:0] secret,
  input  logic              last_turn,
  output logic              busy,
  output logic              done,
  output logic [2:0]        exact,
  output logic [2:0]        partial,
  output logic              win,
  output logic              lose
);

  state_e              state_r;
  state_e              state_s;
  logic [CODE_W-1:0]   guess_r;
  logic [CODE_W-1:0]   secret_r;
  logic                last_turn_r;
  logic [COLOR_W-1:0]  idx_r;
  logic [CNT_W-1:0]    exact_acc_r;
  logic [CNT_W-1:0]    partial_acc_r;
  logic [CNT_W-1:0]    g_hist_r [COLORS];
  logic [CNT_W-1:0]    s_hist_r [COLORS];
  logic                busy_r;
  logic                done_r;
  logic [CNT_W-1:0]    exact_r;
  logic [CNT_W-1:0]    partial_r;
  logic                win_r;
  logic                lose_r;

  logic                start_ok_s;
  logic [COLOR_W-1:0]  g_peg_s;
  logic [COLOR_W-1:0]  s_peg_s;
  logic [CNT_W-1:0]    partial_next_s;

  // Next-state logic and per-cycle datapath terms.
  always_comb begin
    state_s        = state_r;
    start_ok_s     = start & ~win_r & ~lose_r;
    g_peg_s        = peg_slice(guess_r, idx_r[1:0]);
    s_peg_s        = peg_slice(secret_r, idx_r[1:0]);
    partial_next_s = partial_acc_r + min_cnt(g_hist_r[idx_r], s_hist_r[idx_r]);
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = PEG;
        end else begin
          state_s = IDLE;
        end
      end
      PEG: begin
        if (idx_r == LAST_PEG) begin
          state_s = COLOR;
        end else begin
          state_s = PEG;
        end
      end
      COLOR: begin
        if (idx_r == LAST_COLOR) begin
          state_s = IDLE;
        end else begin
          state_s = COLOR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched operands, accumulators, histograms and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      guess_r       <= {CODE_W{1'b0}};
      secret_r      <= {CODE_W{1'b0}};
      last_turn_r   <= 1'b0;
      idx_r         <= 3'd0;
      exact_acc_r   <= 3'd0;
      partial_acc_r <= 3'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      exact_r       <= 3'd0;
      partial_r     <= 3'd0;
      win_r         <= 1'b0;
      lose_r        <= 1'b0;
      for (int c = 0; c < COLORS; c++) begin
        g_hist_r[c] <= 3'd0;
        s_hist_r[c] <= 3'd0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            guess_r       <= guess;
            secret_r      <= secret;
            last_turn_r   <= last_turn;
            idx_r         <= 3'd0;
            exact_acc_r   <= 3'd0;
            partial_acc_r <= 3'd0;
            busy_r        <= 1'b1;
            for (int c = 0; c < COLORS; c++) begin
              g_hist_r[c] <= 3'd0;
              s_hist_r[c] <= 3'd0;
            end
          end
        end
        PEG: begin
          // Only non-matching pegs feed the histograms, so partials exclude exact hits.
          if (g_peg_s == s_peg_s) begin
            exact_acc_r <= exact_acc_r + 3'd1;
          end else begin
            g_hist_r[g_peg_s] <= g_hist_r[g_peg_s] + 3'd1;
            s_hist_r[s_peg_s] <= s_hist_r[s_peg_s] + 3'd1;
          end
          if (idx_r == LAST_PEG) begin
            idx_r <= 3'd0;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        COLOR: begin
          partial_acc_r <= partial_next_s;
          idx_r         <= idx_r + 3'd1;
          if (idx_r == LAST_COLOR) begin
            exact_r   <= exact_acc_r;
            partial_r <= partial_next_s;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            if (exact_acc_r == PEGS_CNT) begin
              win_r <= 1'b1;
            end else if (last_turn_r) begin
              lose_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign exact   = exact_r;
  assign partial = partial_r;
  assign win     = win_r;
  assign lose    = lose_r;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed self-checking bench for guess_scorer with hand-computed scores.
module tb_guess_scorer;
  import mm_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CODE_W-1:0] guess = '0;
  logic [CODE_W-1:0] secret = '0;
  logic              last_turn = 1'b0;
  logic              busy, done, win, lose;
  logic [2:0]        exact, partial;

  int n_cmp = 0;
  int n_err = 0;

  guess_scorer dut (
    .clk(clk), .reset(reset), .start(start), .guess(guess), .secret(secret),
    .last_turn(last_turn), .busy(busy), .done(done), .exact(exact),
    .partial(partial), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tuple order (p0,p1,p2,p3); peg 0 in the LSBs.
  function automatic logic [CODE_W-1:0] code4(input int p0, input int p1, input int p2, input int p3);
    code4 = {p3[2:0], p2[2:0], p1[2:0], p0[2:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Start at next edge E0, then watch 20 cycles; optional extra start pulse sampled at edge inj.
  task automatic run_score(input logic [CODE_W-1:0] g, input logic [CODE_W-1:0] s, input logic lt,
                           input int inj, output int lat, output int ndone, output int busy1);
    lat = -1; ndone = 0; busy1 = 0;
    @(negedge clk);
    guess = g; secret = s; last_turn = lt; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) busy1 = int'(busy);
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      start = (k + 1 == inj);
    end
    start = 1'b0;
  endtask

  // Pulse start once and count any busy/done activity over the following cycles.
  task automatic try_start(output int act);
    act = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (busy || done) act++;
      @(negedge clk);
    end
  endtask

  int lat, nd, b1, act;

  initial begin
    // 1: reset values
    do_reset();
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    chk("rst_exact", exact, 0);  chk("rst_partial", partial, 0);
    chk("rst_win", win, 0);      chk("rst_lose", lose, 0);

    // 2: exact match and timing
    run_score(code4(1,2,3,4), code4(1,2,3,4), 1'b0, 0, lat, nd, b1);
    chk("t2_latency", lat, 12);  chk("t2_ndone", nd, 1);  chk("t2_busy1", b1, 1);
    chk("t2_exact", exact, 4);   chk("t2_partial", partial, 0);
    chk("t2_win", win, 1);       chk("t2_lose", lose, 0);   chk("t2_busy_end", busy, 0);
    try_start(act);
    chk("t2_after_win", act, 0);

    // 3: full permutation
    do_reset();
    chk("t3_win_cleared", win, 0);
    run_score(code4(4,3,2,1), code4(1,2,3,4), 1'b0, 0, lat, nd, b1);
    chk("t3_latency", lat, 12);
    chk("t3_exact", exact, 0);   chk("t3_partial", partial, 4);  chk("t3_win", win, 0);

    // 4: duplicates and disjoint colours
    run_score(code4(1,2,1,1), code4(1,1,2,2), 1'b0, 0, lat, nd, b1);
    chk("t4a_exact", exact, 1);  chk("t4a_partial", partial, 2);
    run_score(code4(5,6,7,5), code4(0,0,0,0), 1'b0, 0, lat, nd, b1);
    chk("t4b_exact", exact, 0);  chk("t4b_partial", partial, 0);  chk("t4b_ndone", nd, 1);
    run_score(code4(0,7,7,0), code4(7,0,0,3), 1'b0, 0, lat, nd, b1);
    chk("t4c_exact", exact, 0);  chk("t4c_partial", partial, 3);

    // 5: start while busy is ignored; losing final turn
    run_score(code4(2,2,3,3), code4(2,3,3,2), 1'b0, 3, lat, nd, b1);
    chk("t5_ndone", nd, 1);      chk("t5_latency", lat, 12);
    chk("t5_exact", exact, 2);   chk("t5_partial", partial, 2);
    run_score(code4(1,2,3,5), code4(1,2,3,4), 1'b1, 0, lat, nd, b1);
    chk("t5_lt_exact", exact, 3); chk("t5_lt_partial", partial, 0);
    chk("t5_lose", lose, 1);     chk("t5_win", win, 0);
    try_start(act);
    chk("t5_after_lose", act, 0);
    chk("t5_lose_hold", lose, 1);

    // 6: reset during COLOR aborts
    do_reset();
    run_score(code4(1,2,1,1), code4(1,1,2,2), 1'b0, 0, lat, nd, b1);
    chk("t6_pre_exact", exact, 1);
    @(negedge clk);
    guess = code4(1,2,3,4); secret = code4(1,2,3,4); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", busy, 0);     chk("t6_done", done, 0);
    chk("t6_exact", exact, 0);   chk("t6_partial", partial, 0);
    chk("t6_win", win, 0);       chk("t6_lose", lose, 0);
    act = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) act++;
      @(negedge clk);
    end
    chk("t6_no_done", act, 0);
    run_score(code4(4,3,2,1), code4(1,2,3,4), 1'b0, 0, lat, nd, b1);
    chk("t6_fresh_lat", lat, 12);
    chk("t6_fresh_exact", exact, 0);  chk("t6_fresh_partial", partial, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
